// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package : riscv_pkg
// Desc    : Shared widths, opcode constants and fetch FSM encoding for the
//           fetch and decode blocks.
// Rev     : 1.0  initial release
// ============================================================================
package riscv_pkg;

    localparam int          DEFAULT_XLEN     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] I_TYPE = 7'b0010011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : instr_fetch_unit_if
// Desc      : Instruction-memory bus, decode handshake and redirect signals.
// Rev       : 1.0  initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [6:0]      opcode;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc, opcode,
        input  instr_ready,
        input  redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc, opcode,
        output instr_ready,
        output redirect, redirect_pc
    );

endinterface : instr_fetch_unit_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Desc   : Power-of-two FIFO with synchronous clear, same-cycle push/pop
//          (also when full) and an occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     clear,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         push_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         pop_data,
    output logic                          empty,
    output logic                          full,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop frees the slot a same-cycle push needs when full.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_unit
// Desc   : PC generation, req/gnt/rvalid instruction fetch, decode buffer and
//          branch-redirect flush with stale-response discard.
// Rev    : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int              XLEN       = riscv_pkg::DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(riscv_pkg::DEFAULT_RESET_PC),
    parameter int              FIFO_DEPTH = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    instr_fetch_unit_if.master bus
);
    import riscv_pkg::*;

    localparam int            AW      = $clog2(FIFO_DEPTH);
    // Headroom above FIFO_DEPTH lets stale requests accumulate across redirects.
    localparam int            CW      = AW + 4;
    localparam logic [CW-1:0] CNT_MAX = '1;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   live;

    logic            issue;
    logic            grant;
    logic            resp;
    logic            pcq_pop;
    logic            ifq_push;
    logic            ifq_pop;

    logic [AW:0]     ifq_count;
    logic [AW:0]     pcq_count;
    logic            ifq_empty;
    logic            ifq_full;
    logic            pcq_empty;
    logic            pcq_full;
    logic [XLEN-1:0] pcq_head;
    logic [2*XLEN-1:0] ifq_head;

    always_comb begin
        live            = outstanding - discard;
        issue           = (state == RUN)
                          && ((live + CW'(ifq_count)) < CW'(FIFO_DEPTH))
                          && (outstanding != CNT_MAX);
        grant           = issue && bus.imem_gnt;
        resp            = bus.imem_rvalid && (outstanding != '0);
        pcq_pop         = resp && (discard == '0);
        ifq_push        = pcq_pop && !bus.redirect;
        ifq_pop         = !ifq_empty && bus.instr_ready;
        outstanding_nxt = outstanding + CW'(grant) - CW'(resp);
    end

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = !ifq_empty;
    assign bus.instr       = ifq_head[2*XLEN-1:XLEN];
    assign bus.instr_pc    = ifq_head[XLEN-1:0];
    assign bus.opcode      = ifq_head[XLEN+6:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     state <= RUN;
                default: state <= BOOT;
            endcase
            outstanding <= outstanding_nxt;
            if (bus.redirect) begin
                // Everything still in flight after this edge belongs to the old path.
                pc      <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                discard <= outstanding_nxt;
            end else begin
                if (grant) begin
                    pc <= pc + XLEN'(4);
                end
                if (resp && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

    // Only live (non-discarded) request PCs are kept; a redirect drops them all.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bus.redirect),
        .push      (grant && !bus.redirect),
        .push_data (pc),
        .pop       (pcq_pop),
        .pop_data  (pcq_head),
        .empty     (pcq_empty),
        .full      (pcq_full),
        .count     (pcq_count)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*XLEN)
    ) u_instr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bus.redirect),
        .push      (ifq_push),
        .push_data ({bus.imem_rdata, pcq_head}),
        .pop       (ifq_pop),
        .pop_data  (ifq_head),
        .empty     (ifq_empty),
        .full      (ifq_full),
        .count     (ifq_count)
    );

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rvalid && (outstanding == '0)));
    a_ifq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(ifq_push && ifq_full && !ifq_pop));
    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(grant && !bus.redirect && pcq_full && !pcq_pop));
    a_pcq_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pcq_pop && pcq_empty));
    a_pcq_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
        pcq_count == live[AW:0]);

endmodule : instr_fetch_unit
`default_nettype wire
